// File: rtl/kb_ps2_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 clock/data lines, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and queues valid scan codes.
module kb_ps2_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       sig_rd_kb,
    output logic [7:0] kb_data,
    output logic       kb_ready,
    output logic       kb_overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rxState_e;

    rxState_e          state, stateNext;
    logic [1:0]        clkSync, dataSync;
    logic              clkPrev;
    logic              fallEdge, rxBit;
    logic [2:0]        bitCnt;
    logic [7:0]        shiftReg;
    logic              parityBit;
    logic [IDLE_W-1:0] idleCnt;
    logic              timeoutHit;
    logic              startFrame, shiftEn, parityEn, stopEn;
    logic              frameValid;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [CNT_W-1:0]  count;
    logic              full, popEn, pushEn;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge on release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], ps2_clk};
            dataSync <= {dataSync[0], ps2_data};
            clkPrev  <= clkSync[1];
        end
    end

    assign fallEdge   = clkPrev & ~clkSync[1];
    assign rxBit      = dataSync[1];
    assign timeoutHit = (state != IDLE) && !fallEdge && (idleCnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        if (timeoutHit) begin
            stateNext = IDLE;
        end else if (fallEdge) begin
            case (state)
                IDLE:    if (!rxBit) stateNext = DATA;
                DATA:    if (bitCnt == 3'd7) stateNext = PARITY;
                PARITY:  stateNext = STOP;
                STOP:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        startFrame = 1'b0;
        shiftEn    = 1'b0;
        parityEn   = 1'b0;
        stopEn     = 1'b0;
        if (fallEdge) begin
            case (state)
                IDLE:    startFrame = !rxBit;
                DATA:    shiftEn    = 1'b1;
                PARITY:  parityEn   = 1'b1;
                STOP:    stopEn     = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            idleCnt   <= '0;
        end else begin
            if (startFrame) bitCnt <= '0;
            if (shiftEn) begin
                shiftReg <= {rxBit, shiftReg[7:1]};
                bitCnt   <= bitCnt + 1'b1;
            end
            if (parityEn) parityBit <= rxBit;
            if (state == IDLE || fallEdge || timeoutHit) idleCnt <= '0;
            else                                         idleCnt <= idleCnt + 1'b1;
        end
    end

    assign frameValid = stopEn && rxBit && (^{shiftReg, parityBit});

    // A push into a full FIFO is still taken when a pop frees the head slot in the same cycle.
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign popEn  = sig_rd_kb && (count != '0);
    assign pushEn = frameValid && (!full || popEn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            kb_overflow <= 1'b0;
        end else begin
            if (popEn)  rdPtr <= rdPtr + 1'b1;
            if (pushEn) wrPtr <= wrPtr + 1'b1;
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (popEn)                     kb_overflow <= 1'b0;
            else if (frameValid && !pushEn) kb_overflow <= 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (pushEn) mem[wrPtr] <= shiftReg;
    end

    assign kb_ready = (count != '0);
    assign kb_data  = kb_ready ? mem[rdPtr] : 8'h00;

endmodule

// File: tb/tb_kb_ps2_rx.sv
// Self-checking bench for kb_ps2_rx: directed scenarios plus randomized frames and reads
// compared against a queue-based model of the scan-code FIFO.
module tb_kb_ps2_rx;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int H     = 8;    // PS/2 half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data, sig_rd_kb;
    logic [7:0] kb_data;
    logic       kb_ready, kb_overflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model[$];
    logic       modelOvf;
    logic       readyN2, readyN3;

    kb_ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .sig_rd_kb(sig_rd_kb), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkFifo(input string tag);
        check({tag, " ready"}, 32'(kb_ready), 32'(model.size() != 0));
        check({tag, " data"}, 32'(kb_data), 32'((model.size() != 0) ? model[0] : 8'h00));
        check({tag, " overflow"}, 32'(kb_overflow), 32'(modelOvf));
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseBit(input logic b);
        ps2_data = b;
        waitCycles(H);
        ps2_clk = 1'b0;
        waitCycles(H);
        ps2_clk = 1'b1;
    endtask

    // Sends one frame; the model applies the receive rules at the stop edge.
    task automatic sendFrame(input logic [7:0] code, input bit badParity, input bit stopBit,
                             input bit rdAtStop, input int stall);
        logic par;
        bit   valid;
        par = ~(^code) ^ badParity;
        pulseBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            pulseBit(code[i]);
            if (i == 3) waitCycles(stall);
        end
        pulseBit(par);
        ps2_data = stopBit;
        waitCycles(H);
        ps2_clk = 1'b0;
        waitCycles(2);
        readyN2 = kb_ready;
        if (rdAtStop) sig_rd_kb = 1'b1;
        waitCycles(1);
        sig_rd_kb = 1'b0;
        readyN3 = kb_ready;
        waitCycles(H - 3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        valid = ((^code) ^ par) && stopBit;
        if (rdAtStop && model.size() != 0) begin
            void'(model.pop_front());
            modelOvf = 1'b0;
        end
        if (valid) begin
            if (model.size() < DEPTH) model.push_back(code);
            else                      modelOvf = 1'b1;
        end
        waitCycles(2);
    endtask

    task automatic readOne(input string tag);
        checkFifo(tag);
        sig_rd_kb = 1'b1;
        waitCycles(1);
        sig_rd_kb = 1'b0;
        if (model.size() != 0) begin
            void'(model.pop_front());
            modelOvf = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        sig_rd_kb = 1'b0;
        modelOvf  = 1'b0;
        waitCycles(3);
        checkFifo("reset");
        rst_n = 1'b1;
        waitCycles(2);

        // Single valid frame, latency, and read
        sendFrame(8'h1C, 1'b0, 1'b1, 1'b0, 0);
        check("latency before", 32'(readyN2), 32'd0);
        check("latency after", 32'(readyN3), 32'd1);
        checkFifo("one frame");
        readOne("one frame read");
        checkFifo("one frame empty");

        // Bad parity and bad stop bit are dropped silently
        sendFrame(8'h1C, 1'b1, 1'b1, 1'b0, 0);
        checkFifo("bad parity");
        sendFrame(8'h1C, 1'b0, 1'b0, 1'b0, 0);
        checkFifo("bad stop");

        // Overflow with 9 frames, then drain
        for (int i = 1; i <= 9; i++) sendFrame(8'(i), 1'b0, 1'b1, 1'b0, 0);
        checkFifo("overflow full");
        for (int i = 0; i < DEPTH; i++) begin
            readOne("overflow drain");
            checkFifo("overflow after pop");
        end

        // Full FIFO with a read coinciding with the stop edge
        for (int i = 0; i < DEPTH; i++) sendFrame(8'(8'h20 + i), 1'b0, 1'b1, 1'b0, 0);
        sendFrame(8'h2F, 1'b0, 1'b1, 1'b1, 0);
        checkFifo("push pop full");
        for (int i = 0; i < DEPTH; i++) readOne("push pop drain");
        checkFifo("push pop empty");

        // Stall shorter than the timeout keeps the frame; a full timeout aborts it
        sendFrame(8'h3D, 1'b0, 1'b1, 1'b0, TMO - 40);
        checkFifo("short stall");
        readOne("short stall read");
        pulseBit(1'b0);
        for (int i = 0; i < 4; i++) pulseBit(1'($urandom_range(0, 1)));
        waitCycles(TMO + 20);
        checkFifo("timeout partial");
        sendFrame(8'hF0, 1'b0, 1'b1, 1'b0, 0);
        checkFifo("timeout next");
        readOne("timeout read");
        checkFifo("timeout empty");

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) sendFrame(8'($urandom), 1'b0, 1'b1, 1'b0, 0);
        checkFifo("pre reset");
        pulseBit(1'b0);
        pulseBit(1'b1);
        pulseBit(1'b0);
        ps2_clk = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model.delete();
        modelOvf = 1'b0;
        checkFifo("async reset");
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(2);
        sendFrame(8'h5A, 1'b0, 1'b1, 1'b0, 0);
        checkFifo("after reset");
        readOne("after reset read");

        // Randomized frames, corrupted frames and reads
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                readOne("rnd read");
            end else begin
                sendFrame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7) != 0,
                          $urandom_range(0, 3) == 0, 0);
            end
            checkFifo("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kb_ps2_rx.md
KB_PS2_RX -- requirements
Module: kb_ps2_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning scan-code FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter TIMEOUT, default 50000, meaning the count of clk cycles with no PS/2 falling edge that aborts a partial frame.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk, input, 1 bit: PS/2 clock from the keyboard; asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: PS/2 data from the keyboard; asynchronous to clk.
REQ-007 SHALL have port sig_rd_kb, input, 1 bit: consumer read strobe; pops one entry per clk cycle while high.
REQ-008 SHALL have port kb_data, output, 8 bits: scan code at the FIFO head.
REQ-009 SHALL have port kb_ready, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port kb_overflow, output, 1 bit: sticky flag, set when a valid frame is dropped because the FIFO is full.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers and detect a ps2_clk falling edge as synced previous=1, current=0; all sampling SHALL use synced data on that edge.
REQ-012 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-013 In IDLE, an edge with data=0 SHALL go to DATA with bit counter=0; an edge with data=1 SHALL stay in IDLE.
REQ-014 In DATA, each edge SHALL shift data into an 8-bit shift register, LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-015 In PARITY, the edge SHALL capture the parity bit and go to STOP.
REQ-016 In STOP, the edge SHALL return to IDLE; the frame is valid only if stop=1 and XOR of the 8 data bits plus the parity bit = 1 (odd parity).
REQ-017 An invalid frame SHALL be discarded silently, with no FIFO write and no flag change.
REQ-018 A valid frame SHALL be pushed into the FIFO on the clk cycle of the stop edge; it is visible on kb_data/kb_ready in the next cycle.
REQ-019 While not in IDLE, an idle counter SHALL increment each cycle with no edge and clear on each edge; on reaching TIMEOUT the FSM SHALL return to IDLE and discard the partial frame.
REQ-020 kb_ready SHALL equal (count != 0); kb_data SHALL equal mem[rd_ptr] combinationally; when the FIFO is empty, kb_data SHALL be 8'h00.
REQ-021 sig_rd_kb=1 with kb_ready=1 SHALL advance rd_ptr modulo FIFO_DEPTH; sig_rd_kb=1 with FIFO empty SHALL be ignored.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-023 A push and pop in the same cycle SHALL both take effect with count unchanged, including when full (no overflow) and when empty (pop ignored, push taken).
REQ-024 A push while full without a simultaneous pop SHALL be dropped and SHALL set kb_overflow=1.
REQ-025 kb_overflow SHALL clear on the cycle after any successful pop.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force the following: FSM to IDLE; bit and idle counters to 0; rd_ptr, wr_ptr and count to 0; synchronisers to 1; kb_ready=0, kb_data=8'h00, kb_overflow=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, the first frame received SHALL start from IDLE.
REQ-028 FIFO memory contents need not be reset.

Verification
REQ-029 SHALL test: a frame for 8'h1C with parity 0 and stop 1 -> kb_ready=1 and kb_data=8'h1C one cycle after the stop edge; pulse sig_rd_kb for 1 cycle -> kb_ready=0.
REQ-030 SHALL test: frame 8'h1C with parity 1, and a separate frame with stop=0 -> kb_ready stays 0 and kb_overflow=0.
REQ-031 SHALL test: 9 valid frames 8'h01..8'h09 with no reads -> kb_overflow=1 and reads return 01..08 in order; kb_overflow=0 after the first pop.
REQ-032 SHALL test: FIFO full, and a frame's stop edge coincides with sig_rd_kb -> count stays 8 and kb_overflow stays 0; the new code appears after the 7 older ones.
REQ-033 SHALL test: ps2_clk stalls for TIMEOUT cycles after 4 data bits, then a full frame 8'hF0 follows -> only 8'hF0 is queued.
REQ-034 SHALL test: rst_n pulsed low mid-frame with 3 entries queued -> kb_ready=0 immediately; the next frame 8'h5A is received correctly.
